minmax_window_tracker: RTL



---
 rtl/minmax_pkg.sv | 19 +
 rtl/minmax_update.sv | 32 +++
 rtl/minmax_window_tracker.sv | 109 ++++++++++
 3 files changed

// File: rtl/minmax_pkg.sv
// Shared types and defaults for the min/max window tracker.
// Macro MINMAX_SIGNED_EN selects two's-complement samples.
package minmax_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int WIN_LEN_DEF = 8;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

`ifdef MINMAX_SIGNED_EN
  typedef logic signed [DATA_W_DEF-1:0] sample_t;
`else
  typedef logic [DATA_W_DEF-1:0] sample_t;
`endif

endpackage

// File: rtl/minmax_update.sv
// Combinational running min/max update for one sample.
// Ports: i_run_min/i_run_max, i_data, i_first -> o_next_min/o_next_max.
// Macro MINMAX_SIGNED_EN: signed compare; otherwise unsigned.
module minmax_update
  import minmax_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_run_min,
  input  logic [DATA_W-1:0] i_run_max,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_first,
  output logic [DATA_W-1:0] o_next_min,
  output logic [DATA_W-1:0] o_next_max
);

  logic w_lt;
  logic w_gt;

`ifdef MINMAX_SIGNED_EN
  assign w_lt = $signed(i_data) < $signed(i_run_min);
  assign w_gt = $signed(i_data) > $signed(i_run_max);
`else
  assign w_lt = i_data < i_run_min;
  assign w_gt = i_data > i_run_max;
`endif

  // Ties keep the old register value.
  assign o_next_min = (i_first || w_lt) ? i_data : i_run_min;
  assign o_next_max = (i_first || w_gt) ? i_data : i_run_max;

endmodule

// File: rtl/minmax_window_tracker.sv
// Tracks min/max over fixed windows of WIN_LEN samples; one result per window.
// Ports: clk, rst (sync, active-high), in_valid/in_ready/in_data sample stream,
//   clear (abort), out_valid/out_ready result stream, out_min, out_max, out_all_eq.
// Macro MINMAX_SIGNED_EN: signed comparisons (see minmax_update).
module minmax_window_tracker
  import minmax_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int WIN_LEN = WIN_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic              out_all_eq
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN_LEN - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_run_min;
  logic [DATA_W-1:0] r_run_max;
  logic [DATA_W-1:0] r_out_min;
  logic [DATA_W-1:0] r_out_max;
  logic              r_out_eq;
  logic [DATA_W-1:0] w_next_min;
  logic [DATA_W-1:0] w_next_max;
  logic              w_accept;
  logic              w_first;
  logic              w_last;

  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == LAST);

  minmax_update #(
    .DATA_W (DATA_W)
  ) u_update (
    .i_run_min  (r_run_min),
    .i_run_max  (r_run_max),
    .i_data     (in_data),
    .i_first    (w_first),
    .o_next_min (w_next_min),
    .o_next_max (w_next_max)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ACC;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ACC: begin
        in_ready = !clear && !rst;
        if (!clear && w_accept && w_last)
          w_next_state = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        // clear wins over a simultaneous out_ready.
        if (clear || out_ready)
          w_next_state = ACC;
      end
      default: w_next_state = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_run_min <= '0;
      r_run_max <= '0;
      r_out_min <= '0;
      r_out_max <= '0;
      r_out_eq  <= 1'b0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_run_min <= w_next_min;
      r_run_max <= w_next_max;
      if (w_last) begin
        r_cnt     <= '0;
        r_out_min <= w_next_min;
        r_out_max <= w_next_max;
        r_out_eq  <= (w_next_min == w_next_max);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign out_min    = r_out_min;
  assign out_max    = r_out_max;
  assign out_all_eq = r_out_eq;

endmodule
